// File: rtl/wb_arbiter_rr.sv
// N-master Wishbone B3 arbiter (fixed or round-robin), whole-cycle ownership, ack timeout.
// Grant lands one cycle after request; waiting masters stall on their own cyc until granted.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                              clock_i,
  input  logic                              reset_n_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic [ADDR_WIDTH-1:0]             adr_o,
  output logic [DATA_WIDTH-1:0]             dat_o,
  output logic [SEL_WIDTH-1:0]              sel_o,
  output logic [2:0]                        cti_o,
  output logic                              we_o,
  output logic                              cyc_o,
  output logic                              stb_o,
  input  logic [DATA_WIDTH-1:0]             dat_i,
  input  logic                              ack_i
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int CL = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CL);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_ERROR} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic [IW:0]   rr_sum;
  logic [IW-1:0] rr_cand;
  logic          own_cyc, own_stb;

  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = m_stb_i[owner_q];
  assign m_dat_o = dat_i;

  // Rotating search starts just after the last winner; i = N-1 wraps back onto it.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    rr_cand = '0;
    if (ROUND_ROBIN != 0) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        rr_sum = {1'b0, ptr_q} + (IW+1)'(i + 1);
        if (rr_sum >= (IW+1)'(NUM_MASTERS)) rr_sum = rr_sum - (IW+1)'(NUM_MASTERS);
        rr_cand = rr_sum[IW-1:0];
        if (!win_vld && m_cyc_i[rr_cand]) begin
          win_vld = 1'b1;
          win_idx = rr_cand;
        end
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (m_cyc_i[i]) begin
          win_vld = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_vld) begin
          owner_d = win_idx;
          ptr_d   = win_idx;
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!own_cyc) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (ack_i) begin
          cnt_d = '0;
        end else if (own_stb) begin
          // Terminal wait cycle only counts when no ack arrives in it.
          if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_ERROR;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    adr_o   = '0;
    dat_o   = '0;
    sel_o   = '0;
    cti_o   = '0;
    we_o    = 1'b0;
    if (state_q == ST_OWNED) begin
      grant_o[owner_q] = 1'b1;
      cyc_o            = own_cyc;
      stb_o            = own_stb;
      adr_o            = m_adr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
      dat_o            = m_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      sel_o            = m_sel_i[int'(owner_q)*SEL_WIDTH +: SEL_WIDTH];
      cti_o            = m_cti_i[int'(owner_q)*3 +: 3];
      we_o             = m_we_i[owner_q];
      m_ack_o[owner_q] = ack_i & own_stb;
    end
    if (state_q == ST_ERROR) m_err_o[owner_q] = 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= LAST_IDX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: a round-robin and a fixed-priority instance share all inputs.
module tb_wb_arbiter_rr;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic [N*3-1:0]  m_cti = '0;
  logic [N-1:0]    m_we = '0, m_cyc = '0, m_stb = '0;
  logic [DW-1:0]   dat_i = '0;
  logic            ack_i = 1'b0;

  logic [N-1:0]  r_ack, r_err, r_grant, f_ack, f_err, f_grant;
  logic [DW-1:0] r_mdat, f_mdat, r_dat, f_dat;
  logic [AW-1:0] r_adr, f_adr;
  logic [SW-1:0] r_sel, f_sel;
  logic [2:0]    r_cti, f_cti;
  logic          r_we, f_we, r_cyc, f_cyc, r_stb, f_stb;

  int checks = 0;
  int failures = 0;
  int mo[2], me[2], mp[2], mw[2];

  always #5 clk = ~clk;

  wb_arbiter_rr #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO)) u_rr (
    .clock_i(clk), .reset_n_i(rst_n), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cti_i(m_cti), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_ack_o(r_ack),
    .m_err_o(r_err), .m_dat_o(r_mdat), .grant_o(r_grant), .adr_o(r_adr), .dat_o(r_dat),
    .sel_o(r_sel), .cti_o(r_cti), .we_o(r_we), .cyc_o(r_cyc), .stb_o(r_stb),
    .dat_i(dat_i), .ack_i(ack_i));

  wb_arbiter_rr #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TO)) u_fx (
    .clock_i(clk), .reset_n_i(rst_n), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cti_i(m_cti), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_ack_o(f_ack),
    .m_err_o(f_err), .m_dat_o(f_mdat), .grant_o(f_grant), .adr_o(f_adr), .dat_o(f_dat),
    .sel_o(f_sel), .cti_o(f_cti), .we_o(f_we), .cyc_o(f_cyc), .stb_o(f_stb),
    .dat_i(dat_i), .ack_i(ack_i));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ctrl = {grant, cyc, stb, ack, err}
  function automatic logic [10:0] act_ctrl(int d);
    return (d == 0) ? {r_grant, r_cyc, r_stb, r_ack, r_err} : {f_grant, f_cyc, f_stb, f_ack, f_err};
  endfunction

  function automatic logic [37:0] act_bus(int d);
    return (d == 0) ? {r_adr, r_dat, r_sel, r_cti, r_we} : {f_adr, f_dat, f_sel, f_cti, f_we};
  endfunction

  task automatic chk_both(input string nm, input logic [10:0] exp);
    chk({nm, " rr"}, 64'(act_ctrl(0)), 64'(exp));
    chk({nm, " fx"}, 64'(act_ctrl(1)), 64'(exp));
  endtask

  // Reference: owner/erring are master indices or -1; mw counts unacked strobe cycles.
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mo[d] = -1; me[d] = -1; mp[d] = N - 1; mw[d] = 0;
    end
  endtask

  function automatic logic [10:0] exp_ctrl(int d);
    logic [2:0] g = '0, a = '0, e = '0;
    logic c = 1'b0, s = 1'b0;
    if (mo[d] >= 0) begin
      g[mo[d]] = 1'b1;
      c = m_cyc[mo[d]];
      s = m_stb[mo[d]];
      a[mo[d]] = ack_i & s;
    end
    if (me[d] >= 0) e[me[d]] = 1'b1;
    return {g, c, s, a, e};
  endfunction

  function automatic logic [37:0] exp_bus(int d);
    int o = mo[d];
    if (o < 0) return '0;
    return {m_adr[o*AW +: AW], m_dat[o*DW +: DW], m_sel[o*SW +: SW], m_cti[o*3 +: 3], m_we[o]};
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (me[d] >= 0) begin
        me[d] = -1;
      end else if (mo[d] < 0) begin
        int w = -1;
        if (d == 0) begin
          for (int k = 1; k <= N; k++)
            if (w < 0 && m_cyc[(mp[d] + k) % N]) w = (mp[d] + k) % N;
        end else begin
          for (int k = N - 1; k >= 0; k--) if (m_cyc[k]) w = k;
        end
        if (w >= 0) begin
          mo[d] = w; mp[d] = w; mw[d] = 0;
        end
      end else if (!m_cyc[mo[d]]) begin
        mo[d] = -1; mw[d] = 0;
      end else if (ack_i) begin
        mw[d] = 0;
      end else if (m_stb[mo[d]]) begin
        mw[d]++;
        if (mw[d] == TO) begin
          me[d] = mo[d]; mo[d] = -1; mw[d] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] cyc;
    logic       ack;
    logic [2:0] g;
    logic       c;
    logic [2:0] a;
  } vec_t;
  vec_t tbl[18];

  initial begin
    tbl[0]  = '{3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001};
    tbl[2]  = '{3'b110, 1'b1, 3'b001, 1'b0, 3'b000};
    tbl[3]  = '{3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 3'b010};
    tbl[5]  = '{3'b101, 1'b1, 3'b010, 1'b0, 3'b000};
    tbl[6]  = '{3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[7]  = '{3'b111, 1'b1, 3'b100, 1'b1, 3'b100};
    tbl[8]  = '{3'b011, 1'b1, 3'b100, 1'b0, 3'b000};
    tbl[9]  = '{3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[10] = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001};
    tbl[11] = '{3'b110, 1'b0, 3'b001, 1'b0, 3'b000};
    tbl[12] = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[13] = '{3'b010, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[14] = '{3'b011, 1'b0, 3'b010, 1'b1, 3'b000};
    tbl[15] = '{3'b001, 1'b0, 3'b010, 1'b0, 3'b000};
    tbl[16] = '{3'b001, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[17] = '{3'b001, 1'b1, 3'b001, 1'b1, 3'b001};

    // Reset held with every master requesting.
    rst_n = 1'b0; m_cyc = 3'b111; m_stb = 3'b111;
    #3;
    chk_both("reset hold", 11'b000_0_0_000_000);
    chk("reset bus", 64'(act_bus(0)), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_both("reset release idle", 11'b000_0_0_000_000);
    tick();
    @(negedge clk);
    chk_both("first grant", 11'b001_1_1_000_000);

    // Round-robin rotation with one-cycle acks.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      m_cyc = tbl[i].cyc; m_stb = tbl[i].cyc; ack_i = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("tbl[%0d] grant/cyc/ack", i), 64'({r_grant, r_cyc, r_ack}),
          64'({tbl[i].g, tbl[i].c, tbl[i].a}));
      tick();
    end

    // Burst lock: master 1 keeps the bus for 4 beats while master 0 waits.
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    tick();
    m_cyc = 3'b011; m_stb = 3'b011;
    for (int b = 0; b < 4; b++) begin
      m_cti[5:3] = (b == 3) ? 3'b111 : 3'b010;
      m_adr[31:16] = 16'(b + 16'h100);
      ack_i = 1'b1;
      @(negedge clk);
      chk_both($sformatf("burst beat %0d", b), 11'b010_1_1_010_000);
      chk($sformatf("burst cti/adr %0d", b), 64'({r_cti, r_adr}),
          64'({((b == 3) ? 3'b111 : 3'b010), 16'(b + 16'h100)}));
      tick();
    end
    m_cyc = 3'b001; m_stb = 3'b001; ack_i = 1'b0;
    @(negedge clk); chk_both("burst release", 11'b010_0_0_000_000);
    tick(); @(negedge clk); chk_both("burst gap", 11'b000_0_0_000_000);
    tick(); @(negedge clk); chk_both("after burst", 11'b001_1_1_000_000);

    // Timeout: master 2 never acked; master 0 waiting behind it.
    do_reset();
    m_cyc = 3'b100; m_stb = 3'b100;
    tick();
    m_cyc = 3'b101; m_stb = 3'b101;
    for (int w = 1; w <= TO; w++) begin
      @(negedge clk); chk_both($sformatf("tmo wait %0d", w), 11'b100_1_1_000_000);
      tick();
    end
    ack_i = 1'b1;
    @(negedge clk); chk_both("tmo err pulse", 11'b000_0_0_000_100);
    tick(); @(negedge clk); chk_both("tmo idle", 11'b000_0_0_000_000);
    ack_i = 1'b0;
    tick(); @(negedge clk); chk_both("tmo next owner", 11'b001_1_1_000_000);

    // Ack on the terminal wait cycle beats the timeout.
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001;
    tick();
    for (int w = 1; w < TO; w++) tick();
    ack_i = 1'b1;
    @(negedge clk); chk_both("ack at terminal", 11'b001_1_1_001_000);
    tick();
    ack_i = 1'b0;
    for (int w = 1; w < TO; w++) begin
      @(negedge clk); chk_both($sformatf("post ack wait %0d", w), 11'b001_1_1_000_000);
      tick();
    end

    // Asynchronous reset in the middle of beat 2.
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    tick();
    ack_i = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_both("async reset drop", 11'b000_0_0_000_000);
    m_cyc = 3'b111; m_stb = 3'b111; ack_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); @(negedge clk); chk_both("post async reset", 11'b001_1_1_000_000);

    // Randomized traffic against the reference model, both priority modes.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(5) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = m_cyc[k] & ($urandom_range(7) != 0);
        m_we[k]  = 1'($urandom);
      end
      m_adr = 48'({$urandom, $urandom});
      m_dat = 48'({$urandom, $urandom});
      m_sel = 6'($urandom);
      m_cti = 9'($urandom);
      dat_i = 16'($urandom);
      ack_i = ((i / 50) % 3 == 2) ? 1'b0 : ($urandom_range(2) == 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rand ctrl d%0d c%0d", d, i), 64'(act_ctrl(d)), 64'(exp_ctrl(d)));
        chk($sformatf("rand bus d%0d c%0d", d, i), 64'(act_bus(d)), 64'(exp_bus(d)));
      end
      chk($sformatf("rand mdat c%0d", i), 64'({r_mdat, f_mdat}), 64'({dat_i, dat_i}));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
